// File: rtl/stream_omega_net_rsp_return.sv
// stream_omega_net_rsp_return
//   Response return path for a stream_omega_net request network. Snoops the
//   request handshakes to remember, per initiator, the order of targets it
//   addressed, then steers target responses (tagged with the initiator index)
//   back to the originating initiators in that initiator's request order.
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_valid_i/ready_i/sel_i  snooped request handshake and target select
//   req_full_o         order FIFO of initiator i is full (gate upstream valid)
//   rsp_data_i/idx_i/valid_i, rsp_ready_o   response streams from targets
//   rsp_data_o/valid_o, rsp_ready_i         response streams to initiators
//   busy_o             at least one response outstanding
module stream_omega_net_rsp_return #(
    parameter int unsigned NumInp   = 4,
    parameter int unsigned NumOut   = 4,
    parameter int unsigned MaxTxns  = 4,
    parameter type         payload_t = logic [31:0],
    parameter bit          SpillReg = 1'b0,
    localparam int unsigned SelW = (NumOut > 1) ? $clog2(NumOut) : 1,
    localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumInp-1:0]                req_valid_i,
    input  logic [NumInp-1:0]                req_ready_i,
    input  logic [NumInp-1:0][SelW-1:0]      req_sel_i,
    output logic [NumInp-1:0]                req_full_o,
    input  payload_t [NumOut-1:0]            rsp_data_i,
    input  logic [NumOut-1:0][IdxW-1:0]      rsp_idx_i,
    input  logic [NumOut-1:0]                rsp_valid_i,
    output logic [NumOut-1:0]                rsp_ready_o,
    output payload_t [NumInp-1:0]            rsp_data_o,
    output logic [NumInp-1:0]                rsp_valid_o,
    input  logic [NumInp-1:0]                rsp_ready_i,
    output logic                             busy_o
);

    localparam int unsigned PtrW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
    localparam int unsigned CntW = $clog2(MaxTxns + 1);

    logic [NumInp-1:0][MaxTxns-1:0][SelW-1:0] mem_q, mem_d;
    logic [NumInp-1:0][PtrW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NumInp-1:0][CntW-1:0]              cnt_q, cnt_d;
    logic [NumInp-1:0]                        spill_vld_q, spill_vld_d;
    payload_t [NumInp-1:0]                    spill_data_q, spill_data_d;

    logic [NumInp-1:0]              full, push, pop, mvld, in_rdy;
    logic [NumInp-1:0][NumOut-1:0]  match;
    payload_t [NumInp-1:0]          mdata;
    logic [NumOut-1:0]              err_idx, err_empty;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTxns - 1)) ? '0 : p + 1'b1;
    endfunction

    // Matching: a response is eligible only if its target is the head of the
    // addressed initiator's order FIFO; anything else stays stalled.
    always_comb begin
        match = '0;
        mvld  = '0;
        mdata = '0;
        for (int i = 0; i < NumInp; i++) begin
            full[i] = (cnt_q[i] == CntW'(MaxTxns));
            push[i] = req_valid_i[i] && req_ready_i[i] && !full[i];
            for (int j = 0; j < NumOut; j++) begin
                match[i][j] = !rst_i && rsp_valid_i[j]
                              && (rsp_idx_i[j] == IdxW'(i))
                              && (cnt_q[i] != '0)
                              && (mem_q[i][rptr_q[i]] == SelW'(j));
                if (match[i][j]) begin
                    mvld[i]  = 1'b1;
                    mdata[i] = rsp_data_i[j];
                end
            end
            // With the output register, accept whenever it is empty or draining.
            in_rdy[i] = SpillReg ? (!spill_vld_q[i] || rsp_ready_i[i]) : rsp_ready_i[i];
            pop[i]    = mvld[i] && in_rdy[i];
        end
    end

    always_comb begin
        rsp_ready_o = '0;
        for (int j = 0; j < NumOut; j++) begin
            for (int i = 0; i < NumInp; i++) begin
                if (match[i][j] && in_rdy[i]) rsp_ready_o[j] = 1'b1;
            end
        end
    end

    always_comb begin
        req_full_o = full;
        if (SpillReg) begin
            rsp_valid_o = spill_vld_q;
            rsp_data_o  = spill_data_q;
        end else begin
            rsp_valid_o = mvld;
            rsp_data_o  = mdata;
        end
        busy_o = |spill_vld_q;
        for (int i = 0; i < NumInp; i++) begin
            if (cnt_q[i] != '0) busy_o = 1'b1;
        end
    end

    // Next state for the order FIFOs and the optional output registers.
    always_comb begin
        mem_d        = mem_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        spill_vld_d  = spill_vld_q;
        spill_data_d = spill_data_q;
        for (int i = 0; i < NumInp; i++) begin
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = req_sel_i[i];
                wptr_d[i]           = ptr_inc(wptr_q[i]);
            end
            if (pop[i]) rptr_d[i] = ptr_inc(rptr_q[i]);
            if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + 1'b1;
            else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - 1'b1;
            if (in_rdy[i]) spill_vld_d[i] = mvld[i];
            if (pop[i]) spill_data_d[i] = mdata[i];
        end
        if (!SpillReg) spill_vld_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            spill_vld_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            spill_vld_q <= spill_vld_d;
        end
        mem_q        <= mem_d;
        spill_data_q <= spill_data_d;
    end

    // Protocol errors: out-of-range index or response with no outstanding request.
    always_comb begin
        err_idx   = '0;
        err_empty = '0;
        for (int j = 0; j < NumOut; j++) begin
            err_idx[j] = rsp_valid_i[j];
            for (int i = 0; i < NumInp; i++) begin
                if (rsp_idx_i[j] == IdxW'(i)) begin
                    err_idx[j]   = 1'b0;
                    err_empty[j] = rsp_valid_i[j] && (cnt_q[i] == '0);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NumInp; i++) begin
                assert (!(req_valid_i[i] && req_ready_i[i] && full[i]))
                    else $error("request push while order FIFO %0d is full", i);
            end
            for (int j = 0; j < NumOut; j++) begin
                assert (!err_idx[j])
                    else $error("target %0d response index out of range", j);
                assert (!err_empty[j])
                    else $error("target %0d response for initiator with no outstanding request", j);
            end
        end
    end

endmodule

// File: tb/tb_stream_omega_net_rsp_return.sv
module tb_stream_omega_net_rsp_return;

    localparam int NREQ   = 20000;
    localparam int BUDGET = 45000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    bit   act;

    logic [3:0]       req_valid, req_ready, rsp_valid, out_ready;
    logic [3:0][1:0]  req_sel, rsp_idx;
    logic [3:0][31:0] rsp_data;

    logic [3:0]       full0, full1, trdy0, trdy1, ovld0, ovld1;
    logic [3:0][31:0] odat0, odat1;
    logic             busy0, busy1;

    logic [3:0]       full, trdy, ovld;
    logic [3:0][31:0] odat;
    logic             busy;
    assign full = act ? full1 : full0;
    assign trdy = act ? trdy1 : trdy0;
    assign ovld = act ? ovld1 : ovld0;
    assign odat = act ? odat1 : odat0;
    assign busy = act ? busy1 : busy0;

    stream_omega_net_rsp_return #(.NumInp(4), .NumOut(4), .MaxTxns(4), .SpillReg(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst0),
        .req_valid_i(req_valid), .req_ready_i(req_ready), .req_sel_i(req_sel), .req_full_o(full0),
        .rsp_data_i(rsp_data), .rsp_idx_i(rsp_idx), .rsp_valid_i(rsp_valid), .rsp_ready_o(trdy0),
        .rsp_data_o(odat0), .rsp_valid_o(ovld0), .rsp_ready_i(out_ready), .busy_o(busy0)
    );

    stream_omega_net_rsp_return #(.NumInp(4), .NumOut(4), .MaxTxns(4), .SpillReg(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1),
        .req_valid_i(req_valid), .req_ready_i(req_ready), .req_sel_i(req_sel), .req_full_o(full1),
        .rsp_data_i(rsp_data), .rsp_idx_i(rsp_idx), .rsp_valid_i(rsp_valid), .rsp_ready_o(trdy1),
        .rsp_data_o(odat1), .rsp_valid_o(ovld1), .rsp_ready_i(out_ready), .busy_o(busy1)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  ini;
        logic [31:0] data;
        int          avail;
    } tr_t;

    tr_t         tq[4][$];    // per-target responses owed, in arrival order
    logic [31:0] expq[4][$];  // per-initiator payloads expected, in request order

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_valid = '0;
        req_ready = '0;
        req_sel   = '0;
        rsp_valid = '0;
        rsp_idx   = '0;
        rsp_data  = '0;
        out_ready = 4'hF;
    endtask

    task automatic push1(input int i, input logic [1:0] s);
        req_valid[i] = 1'b1;
        req_ready[i] = 1'b1;
        req_sel[i]   = s;
        tick();
        req_valid[i] = 1'b0;
        req_ready[i] = 1'b0;
    endtask

    task automatic tgt(input int j, input int i, input logic [31:0] d);
        rsp_valid[j] = 1'b1;
        rsp_idx[j]   = 2'(i);
        rsp_data[j]  = d;
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < 4; i++) n += expq[i].size();
        return n;
    endfunction

    task automatic run_random(input bit mode);
        int          sent, cyc, nplan;
        int          stall[4];
        logic [3:0]  pres, hold, thk, pk;
        logic [31:0] hdata[4];
        logic [31:0] d;
        tr_t         t;
        act  = mode;
        quiet();
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) tick();
        if (mode) rst1 = 1'b0;
        else rst0 = 1'b0;
        sent = 0;
        cyc  = 0;
        pres = '0;
        hold = '0;
        for (int i = 0; i < 4; i++) stall[i] = 0;
        while ((sent < NREQ || pending() != 0) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            nplan = 0;
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = 1'b0;
                req_sel[i]   = 2'($urandom_range(0, 3));
                req_ready[i] = ($urandom_range(0, 3) != 0);
                if (!full[i] && (sent + nplan) < NREQ && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    if (req_ready[i]) nplan++;
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (!pres[j] && tq[j].size() > 0 && tq[j][0].avail <= cyc && $urandom_range(0, 3) != 0)
                    pres[j] = 1'b1;
                rsp_valid[j] = pres[j];
                if (pres[j]) begin
                    rsp_idx[j]  = tq[j][0].ini;
                    rsp_data[j] = tq[j][0].data;
                end else begin
                    rsp_idx[j]  = 2'($urandom_range(0, 3));
                    rsp_data[j] = $urandom;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (stall[i] > 0) begin
                    out_ready[i] = 1'b0;
                    stall[i]--;
                end else begin
                    out_ready[i] = 1'b1;
                    if ($urandom_range(0, 3) == 0) stall[i] = $urandom_range(0, 5);
                end
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hold[i]) begin
                    chk("rnd_hold_vld", ovld[i], 1'b1);
                    chk("rnd_hold_data", odat[i], hdata[i]);
                end
                if (ovld[i] && out_ready[i]) begin
                    if (expq[i].size() == 0) chk("rnd_unexpected_vld", ovld[i], 1'b0);
                    else chk("rnd_data", odat[i], expq[i].pop_front());
                end
                hold[i]  = ovld[i] && !out_ready[i];
                hdata[i] = odat[i];
                pk[i]    = req_valid[i] && req_ready[i];
            end
            for (int j = 0; j < 4; j++) thk[j] = pres[j] && trdy[j];
            @(posedge clk);
            for (int j = 0; j < 4; j++) begin
                if (thk[j]) begin
                    void'(tq[j].pop_front());
                    pres[j] = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (pk[i]) begin
                    d       = $urandom;
                    t.ini   = 2'(i);
                    t.data  = d;
                    t.avail = cyc + 1;
                    tq[req_sel[i]].push_back(t);
                    expq[i].push_back(d);
                    sent++;
                end
            end
        end
        chk("rnd_sent", sent, NREQ);
        chk("rnd_drained", pending(), 0);
        @(negedge clk);
        quiet();
        repeat (2) @(negedge clk);
        chk("rnd_busy_end", busy, 1'b0);
        for (int j = 0; j < 4; j++) tq[j].delete();
        for (int i = 0; i < 4; i++) expq[i].delete();
    endtask

    initial begin
        logic [1:0] wq[$];
        logic [1:0] s, h;
        logic       exp_full;
        act  = 1'b0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        quiet();
        repeat (3) tick();
        rst0 = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_vld", ovld, 4'h0);
        chk("rst_full", full, 4'h0);
        chk("rst_trdy", trdy, 4'h0);

        // reset with three outstanding requests
        req_valid = 4'b0111;
        req_ready = 4'b0111;
        req_sel   = {2'd0, 2'd2, 2'd1, 2'd0};
        tick();
        quiet();
        #1;
        chk("t1_busy_before", busy, 1'b1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        #1;
        chk("t1_busy", busy, 1'b0);
        chk("t1_vld", ovld, 4'h0);
        chk("t1_full", full, 4'h0);

        // in-order return: targets 2 then 1, target 1 answers first
        push1(0, 2'd2);
        push1(0, 2'd1);
        tgt(1, 0, 32'h1111_0001);
        #1;
        chk("t2_trdy1_early", trdy[1], 1'b0);
        chk("t2_vld_early", ovld[0], 1'b0);
        tick();
        tgt(2, 0, 32'h2222_0002);
        #1;
        chk("t2_vld_a", ovld[0], 1'b1);
        chk("t2_data_a", odat[0], 32'h2222_0002);
        chk("t2_trdy2", trdy[2], 1'b1);
        chk("t2_trdy1_blocked", trdy[1], 1'b0);
        tick();
        rsp_valid[2] = 1'b0;
        #1;
        chk("t2_vld_b", ovld[0], 1'b1);
        chk("t2_data_b", odat[0], 32'h1111_0001);
        chk("t2_trdy1", trdy[1], 1'b1);
        tick();
        quiet();
        #1;
        chk("t2_busy", busy, 1'b0);

        // full on initiator 3, no bypass on pop
        for (int k = 0; k < 4; k++) begin
            push1(3, 2'(k));
            #1;
            exp_full = (k == 3);
            chk("t3_full_fill", full[3], exp_full);
        end
        tgt(0, 3, 32'h3333_0000);
        #1;
        chk("t3_vld", ovld[3], 1'b1);
        chk("t3_full_nobypass", full[3], 1'b1);
        tick();
        rsp_valid[0] = 1'b0;
        #1;
        chk("t3_full_clear", full[3], 1'b0);
        for (int k = 1; k < 4; k++) begin
            tgt(k, 3, 32'h3333_0000 + k);
            #1;
            chk("t3_drain", odat[3], 32'h3333_0000 + k);
            tick();
            rsp_valid[k] = 1'b0;
        end
        #1;
        chk("t3_busy", busy, 1'b0);

        // simultaneous push and pop on FIFO 1 at count 2
        push1(1, 2'd0);
        push1(1, 2'd1);
        req_valid[1] = 1'b1;
        req_ready[1] = 1'b1;
        req_sel[1]   = 2'd2;
        tgt(0, 1, 32'h4444_0000);
        #1;
        chk("t4_pp_data", odat[1], 32'h4444_0000);
        chk("t4_pp_trdy", trdy[0], 1'b1);
        tick();
        quiet();
        push1(1, 2'd3);
        #1;
        chk("t4_cnt3", full[1], 1'b0);
        push1(1, 2'd0);
        #1;
        chk("t4_cnt4", full[1], 1'b1);
        wq = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 4; k++) begin
            h = wq.pop_front();
            tgt(h, 1, 32'h4444_0010 + k);
            #1;
            chk("t4_drain_vld", ovld[1], 1'b1);
            chk("t4_drain_data", odat[1], 32'h4444_0010 + k);
            tick();
            quiet();
        end

        // wrap-around: ten back-to-back push/pop pairs
        s = 2'($urandom_range(0, 3));
        push1(1, s);
        wq.push_back(s);
        for (int n = 0; n < 10; n++) begin
            s            = 2'($urandom_range(0, 3));
            req_valid[1] = 1'b1;
            req_ready[1] = 1'b1;
            req_sel[1]   = s;
            h            = wq.pop_front();
            tgt(h, 1, 32'h5000_0000 + n);
            #1;
            chk("t4_wrap_vld", ovld[1], 1'b1);
            chk("t4_wrap_data", odat[1], 32'h5000_0000 + n);
            tick();
            quiet();
            wq.push_back(s);
        end
        h = wq.pop_front();
        tgt(h, 1, 32'h5000_00FF);
        #1;
        chk("t4_wrap_last", odat[1], 32'h5000_00FF);
        tick();
        quiet();
        #1;
        chk("t4_busy", busy, 1'b0);

        // backpressure on initiator 0
        push1(0, 2'd3);
        out_ready[0] = 1'b0;
        tgt(3, 0, 32'h5555_AAAA);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_vld", ovld[0], 1'b1);
            chk("t5_data", odat[0], 32'h5555_AAAA);
            chk("t5_trdy_stall", trdy[3], 1'b0);
            tick();
        end
        out_ready[0] = 1'b1;
        #1;
        chk("t5_trdy_go", trdy[3], 1'b1);
        tick();
        quiet();
        #1;
        chk("t5_busy", busy, 1'b0);

        run_random(1'b0);
        run_random(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
